// File: rtl/tick_gen_pkg.sv
// Shared constants and types for the tick/square-wave generator.
//   MODE_PERIODIC / MODE_ONESHOT : channel run modes
//   chan_state_e                 : per-channel state (IDLE = 0, RUN = 1)
//   DEF_DIV                      : reset divisor, 100 Hz square wave at CLK_HZ
//   CLK_HZ                       : system clock frequency
package tick_gen_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } chan_state_e;

  localparam int unsigned DEF_DIV = 500_000;
  localparam int unsigned CLK_HZ  = 100_000_000;

endpackage

// File: rtl/tick_chan.sv
// One tick/square-wave channel: counter, shadow and active divisor/mode, run state.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_cfg_we     : write shadow divisor/mode of this channel
//   i_cfg_div    : new divisor (0 is treated as 1)
//   i_cfg_mode   : 0 periodic, 1 one-shot
//   i_start      : start/restart pulse
//   i_stop       : stop pulse (wins over i_start)
//   o_tick       : one-cycle pulse at terminal count
//   o_sq         : toggles at terminal count
//   o_busy       : channel is running
module tick_chan #(
  parameter int unsigned CNT_W      = 27,
  parameter int unsigned DEF_DIV    = tick_gen_pkg::DEF_DIV,
  parameter bit          AUTO_START = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cfg_we,
  input  logic [CNT_W-1:0] i_cfg_div,
  input  logic             i_cfg_mode,
  input  logic             i_start,
  input  logic             i_stop,
  output logic             o_tick,
  output logic             o_sq,
  output logic             o_busy
);
  import tick_gen_pkg::*;

  chan_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_div;
  logic             r_mode;
  logic [CNT_W-1:0] r_sdiv;
  logic             r_smode;
  logic             r_tick;
  logic             r_sq;

  logic [CNT_W-1:0] w_cfg_div;
  logic             w_terminal;

  always_comb begin
    w_cfg_div  = (i_cfg_div == '0) ? CNT_W'(1) : i_cfg_div;
    // r_div is never 0, so div-1 cannot underflow.
    w_terminal = (r_cnt == r_div - 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= AUTO_START ? StRun : StIdle;
      r_cnt   <= '0;
      r_div   <= CNT_W'(DEF_DIV);
      r_mode  <= MODE_PERIODIC;
      r_sdiv  <= CNT_W'(DEF_DIV);
      r_smode <= MODE_PERIODIC;
      r_tick  <= 1'b0;
      r_sq    <= 1'b0;
    end else begin
      // Loads below read the pre-write shadow; a same-cycle write applies at the next load.
      if (i_cfg_we) begin
        r_sdiv  <= w_cfg_div;
        r_smode <= i_cfg_mode;
      end

      if (i_stop) begin
        r_state <= StIdle;
        r_cnt   <= '0;
        r_tick  <= 1'b0;
        r_sq    <= 1'b0;
      end else if (i_start) begin
        // tick/sq deliberately left as they are.
        r_state <= StRun;
        r_cnt   <= '0;
        r_div   <= r_sdiv;
        r_mode  <= r_smode;
      end else if (r_state == StRun) begin
        if (w_terminal) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          r_sq   <= ~r_sq;
          r_div  <= r_sdiv;
          r_mode <= r_smode;
          // The mode of the period that just ended decides whether to continue.
          if (r_mode == MODE_ONESHOT) begin
            r_state <= StIdle;
          end
        end else begin
          r_cnt  <= r_cnt + 1'b1;
          r_tick <= 1'b0;
        end
      end else begin
        r_cnt  <= '0;
        r_tick <= 1'b0;
      end
    end
  end

  assign o_tick = r_tick;
  assign o_sq   = r_sq;
  assign o_busy = (r_state == StRun);

endmodule

// File: rtl/tick_gen.sv
// Multi-channel tick and 50 % square-wave generator.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cfg_we     : write shadow divisor/mode of channel cfg_ch
//   cfg_ch     : target channel; values >= N_CH are ignored
//   cfg_div    : new divisor (0 is treated as 1)
//   cfg_mode   : 0 periodic, 1 one-shot
//   start      : per-channel start/restart pulse
//   stop       : per-channel stop pulse
//   tick       : per-channel one-cycle pulse at terminal count
//   sq         : per-channel square wave, period 2*div
//   busy       : per-channel running flag
module tick_gen #(
  parameter int unsigned       N_CH       = 4,
  parameter int unsigned       CNT_W      = 27,
  parameter int unsigned       DEF_DIV    = tick_gen_pkg::DEF_DIV,
  parameter logic [N_CH-1:0]   AUTO_START = '0,
  localparam int unsigned      CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic             cfg_mode,
  input  logic [N_CH-1:0]  start,
  input  logic [N_CH-1:0]  stop,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  sq,
  output logic [N_CH-1:0]  busy
);
  import tick_gen_pkg::*;

  logic [N_CH-1:0] w_cfg_we;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    // Out-of-range cfg_ch matches no channel, so the write is dropped.
    assign w_cfg_we[i] = cfg_we && (cfg_ch == CH_W'(i));

    tick_chan #(
      .CNT_W      (CNT_W),
      .DEF_DIV    (DEF_DIV),
      .AUTO_START (AUTO_START[i])
    ) u_chan (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_cfg_we   (w_cfg_we[i]),
      .i_cfg_div  (cfg_div),
      .i_cfg_mode (cfg_mode),
      .i_start    (start[i]),
      .i_stop     (stop[i]),
      .o_tick     (tick[i]),
      .o_sq       (sq[i]),
      .o_busy     (busy[i])
    );
  end

endmodule

// File: tb/tb_tick_gen.sv
// Bench for tick_gen: two instances sharing one stimulus bus.
//   A: 4 channels, default divisor 500000, no auto-start.
//   B: 3 channels, default divisor 7, channel 0 auto-starts; cfg_ch = 3 is out of range.
// A deadline-based model predicts every output each cycle; directed checks pin it.
module tb_tick_gen;

  localparam int unsigned CW = 27;
  localparam int unsigned DA = 500_000;
  localparam int unsigned DB = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [CW-1:0] cfg_div = '0;
  logic          cfg_mode = 1'b0;
  logic [3:0]    start = '0;
  logic [3:0]    stop = '0;
  logic [3:0]    tick_a, sq_a, busy_a;
  logic [2:0]    tick_b, sq_b, busy_b;

  int total = 0;
  int bad = 0;

  tick_gen #(
    .N_CH       (4),
    .CNT_W      (CW),
    .DEF_DIV    (DA),
    .AUTO_START (4'b0000)
  ) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .start    (start),
    .stop     (stop),
    .tick     (tick_a),
    .sq       (sq_a),
    .busy     (busy_a)
  );

  tick_gen #(
    .N_CH       (3),
    .CNT_W      (CW),
    .DEF_DIV    (DB),
    .AUTO_START (3'b001)
  ) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_we   (cfg_we),
    .cfg_ch   (cfg_ch),
    .cfg_div  (cfg_div),
    .cfg_mode (cfg_mode),
    .start    (start[2:0]),
    .stop     (stop[2:0]),
    .tick     (tick_b),
    .sq       (sq_b),
    .busy     (busy_b)
  );

  initial forever #5 clk = ~clk;

  // Model: channels 0..3 are A, 4..6 are B. Each running channel has an absolute
  // edge number (due) at which its tick rises.
  bit m_run[7], m_tick[7], m_sq[7], m_mode[7], m_smode[7];
  int m_per[7], m_sdiv[7], m_due[7];
  int cyc = 0;

  function automatic void model_reset();
    for (int m = 0; m < 7; m++) begin
      m_sdiv[m]  = (m < 4) ? DA : DB;
      m_per[m]   = m_sdiv[m];
      m_mode[m]  = 1'b0;
      m_smode[m] = 1'b0;
      m_tick[m]  = 1'b0;
      m_sq[m]    = 1'b0;
      m_run[m]   = (m == 4);
      m_due[m]   = cyc + m_per[m];
    end
  endfunction

  function automatic void model_step();
    int j;
    cyc++;
    for (int m = 0; m < 7; m++) begin
      j = (m < 4) ? m : m - 4;
      if (stop[j]) begin
        m_run[m] = 1'b0; m_tick[m] = 1'b0; m_sq[m] = 1'b0;
      end else if (start[j]) begin
        m_run[m] = 1'b1; m_per[m] = m_sdiv[m]; m_mode[m] = m_smode[m];
        m_due[m] = cyc + m_per[m];
      end else if (m_run[m] && cyc == m_due[m]) begin
        m_tick[m] = 1'b1; m_sq[m] = ~m_sq[m];
        if (m_mode[m]) m_run[m] = 1'b0;
        m_per[m] = m_sdiv[m]; m_mode[m] = m_smode[m];
        m_due[m] = cyc + m_per[m];
      end else begin
        m_tick[m] = 1'b0;
      end
      if (cfg_we && cfg_ch == 2'(j)) begin
        m_sdiv[m]  = (cfg_div == '0) ? 1 : int'(cfg_div);
        m_smode[m] = cfg_mode;
      end
    end
  endfunction

  // Per-cycle compare against the model.
  initial begin
    logic [3:0] et_a, es_a, eb_a;
    logic [2:0] et_b, es_b, eb_b;
    forever begin
      @(negedge clk);
      for (int m = 0; m < 4; m++) begin
        et_a[m] = m_tick[m]; es_a[m] = m_sq[m]; eb_a[m] = m_run[m];
      end
      for (int m = 0; m < 3; m++) begin
        et_b[m] = m_tick[m+4]; es_b[m] = m_sq[m+4]; eb_b[m] = m_run[m+4];
      end
      total++;
      if ({tick_a, sq_a, busy_a} !== {et_a, es_a, eb_a}) begin
        bad++;
        $display("FAIL model_a cyc=%0d got tick=%b sq=%b busy=%b exp tick=%b sq=%b busy=%b",
                 cyc, tick_a, sq_a, busy_a, et_a, es_a, eb_a);
      end
      total++;
      if ({tick_b, sq_b, busy_b} !== {et_b, es_b, eb_b}) begin
        bad++;
        $display("FAIL model_b cyc=%0d got tick=%b sq=%b busy=%b exp tick=%b sq=%b busy=%b",
                 cyc, tick_b, sq_b, busy_b, et_b, es_b, eb_b);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got %0h expected %0h", nm, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic cfg(input int ch, input int d, input bit md);
    cfg_we = 1'b1; cfg_ch = 2'(ch); cfg_div = CW'(d); cfg_mode = md;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic go(input logic [3:0] st, input logic [3:0] sp);
    start = st; stop = sp;
    step();
    start = '0; stop = '0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_busy_a", 32'(busy_a), 32'h0);
    chk("rst_tick_a", 32'(tick_a), 32'h0);
    chk("rst_sq_a", 32'(sq_a), 32'h0);
    chk("rst_busy_b", 32'(busy_b), 32'h1);
    rst_n = 1'b1;

    // B ch0 auto-started at default divisor 7.
    repeat (6) step();
    chk("auto_pre", 32'(tick_b[0]), 32'h0);
    step();
    chk("auto_tick", 32'(tick_b[0]), 32'h1);
    chk("auto_sq", 32'(sq_b[0]), 32'h1);

    // Periodic div 4 on ch0.
    cfg(0, 4, 1'b0);
    go(4'b0001, 4'b0000);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("div4_tick", 32'(tick_a[0]), 32'((k % 4) == 0));
    end
    chk("div4_sq", 32'(sq_a[0]), 32'h1);
    chk("div4_quiet", 32'(tick_a[3:1]), 32'h0);

    // Shadow update mid-period, and a write coinciding with a terminal count.
    cfg(0, 5, 1'b0);
    go(4'b0001, 4'b0000);
    for (int k = 1; k <= 24; k++) begin
      if (k == 2) begin cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = CW'(3); end
      if (k == 14) begin cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = CW'(6); end
      step();
      cfg_we = 1'b0;
      chk("shadow_tick", 32'(tick_a[0]),
          32'(k == 5 || k == 8 || k == 11 || k == 14 || k == 17 || k == 23));
    end
    go(4'b0000, 4'b0001);
    chk("stop_busy", 32'(busy_a[0]), 32'h0);
    chk("stop_sq", 32'(sq_a[0]), 32'h0);

    // One-shot div 6 on ch1.
    cfg(1, 6, 1'b1);
    go(4'b0010, 4'b0000);
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("os_tick", 32'(tick_a[1]), 32'(k == 6));
      chk("os_busy", 32'(busy_a[1]), 32'(k < 6));
    end

    // Start and stop together on ch2.
    cfg(2, 2, 1'b0);
    go(4'b0100, 4'b0000);
    repeat (3) step();
    chk("ss_sq_pre", 32'(sq_a[2]), 32'h1);
    go(4'b0100, 4'b0100);
    chk("ss_busy", 32'(busy_a[2]), 32'h0);
    chk("ss_sq", 32'(sq_a[2]), 32'h0);

    // Restart mid-period on ch3.
    cfg(3, 5, 1'b0);
    go(4'b1000, 4'b0000);
    repeat (3) step();
    go(4'b1000, 4'b0000);
    for (int k = 1; k <= 7; k++) begin
      step();
      chk("restart_tick", 32'(tick_a[3]), 32'(k == 5));
    end

    // cfg_ch = 3 is beyond B's channels: B ch0 keeps its shadow div 6, periodic.
    cfg(3, 2, 1'b1);
    go(4'b0001, 4'b0000);
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("oob_tick_b", 32'(tick_b[0]), 32'(k == 6));
    end
    chk("oob_busy_b", 32'(busy_b[0]), 32'h1);
    go(4'b0000, 4'b1111);

    // Divisor 0 behaves as 1.
    cfg(2, 0, 1'b0);
    go(4'b0100, 4'b0000);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("div0_tick", 32'(tick_a[2]), 32'h1);
      chk("div0_sq", 32'(sq_a[2]), 32'(k % 2));
    end

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tick_a", 32'(tick_a), 32'h0);
    chk("arst_sq_a", 32'(sq_a), 32'h0);
    chk("arst_busy_a", 32'(busy_a), 32'h0);
    chk("arst_busy_b", 32'(busy_b), 32'h1);
    chk("arst_sq_b", 32'(sq_b), 32'h0);
    model_reset();
    #1 rst_n = 1'b1;
    repeat (6) step();
    chk("arst_pre", 32'(tick_b[0]), 32'h0);
    step();
    chk("arst_tick_b", 32'(tick_b[0]), 32'h1);
    chk("arst_idle_a", 32'(busy_a), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
